// File: rtl/adc_sampler_avg.sv
// adc_sampler_avg: parallel-ADC front end with programmable decimation and power-of-two moving average.
// Define ADC_SAMPLER_AVG_MA_EN to build the averager; otherwise a single register stage replaces it.
module adc_sampler_avg #(
  parameter int BITS_ADC           = 8,
  parameter int ADC_DF_WIDTH       = 32,
  parameter int MA_ACUM_WIDTH      = 12,
  parameter int REG_DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH     = 8,
  parameter int ADC_DF_DV_REG      = 0,
  parameter int MA_K_FACTOR_DV_REG = 3,
  parameter int REG_ADDR_ADC_DF_L  = 0,
  parameter int REG_ADDR_ADC_DF_H  = 1,
  parameter int REG_ADDR_MOV_AVE_K = 2
) (
  input  logic                      clk_i,
  input  logic                      rst,
  input  logic [BITS_ADC-1:0]       adc_data_i,
  output logic                      adc_oe,
  output logic                      clk_o,
  output logic [BITS_ADC-1:0]       si_data_o,
  output logic                      si_rdy_o,
  input  logic [REG_DATA_WIDTH-1:0] reg_si_data,
  input  logic [REG_ADDR_WIDTH-1:0] reg_si_addr,
  input  logic                      reg_si_rdy
);

  localparam int K_W    = $clog2(MA_ACUM_WIDTH - BITS_ADC);
  localparam int DF_H_W = ADC_DF_WIDTH - REG_DATA_WIDTH;

  // Neither bus has back-pressure: si_data_o is valid only in the single cycle si_rdy_o is high,
  // and reg_si_rdy marks a register write that is always accepted in the cycle it is high.

  logic                    hit_l, hit_h, hit_k;
  logic [ADC_DF_WIDTH-1:0] df;
  logic [K_W-1:0]          k;
  logic                    restart;
  logic [ADC_DF_WIDTH-1:0] dec_cnt;
  logic [BITS_ADC-1:0]     sample;
  logic                    sample_vld;
  logic [BITS_ADC-1:0]     avg;
  logic                    avg_vld;

  assign clk_o  = ~clk_i;
  assign adc_oe = ~restart;

  assign hit_l = (reg_si_addr == REG_ADDR_WIDTH'(REG_ADDR_ADC_DF_L));
  assign hit_h = (reg_si_addr == REG_ADDR_WIDTH'(REG_ADDR_ADC_DF_H));
  assign hit_k = (reg_si_addr == REG_ADDR_WIDTH'(REG_ADDR_MOV_AVE_K));

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      df      <= ADC_DF_WIDTH'(ADC_DF_DV_REG);
      k       <= K_W'(MA_K_FACTOR_DV_REG);
      restart <= 1'b1;
    end else begin
      restart <= reg_si_rdy && (hit_l || hit_h || hit_k);
      if (reg_si_rdy && hit_l) df[REG_DATA_WIDTH-1:0] <= reg_si_data;
      if (reg_si_rdy && hit_h) df[ADC_DF_WIDTH-1:REG_DATA_WIDTH] <= reg_si_data[DF_H_W-1:0];
      if (reg_si_rdy && hit_k) k <= reg_si_data[K_W-1:0];
    end
  end

  // The counter is compared as the word is captured, so the decimation flag travels with its sample.
  always_ff @(posedge clk_i) begin
    if (!rst || restart) begin
      dec_cnt    <= '0;
      sample     <= '0;
      sample_vld <= 1'b0;
    end else begin
      sample     <= adc_data_i;
      sample_vld <= (dec_cnt == df);
      dec_cnt    <= (dec_cnt == df) ? '0 : dec_cnt + ADC_DF_WIDTH'(1);
    end
  end

`ifdef ADC_SAMPLER_AVG_MA_EN
  localparam int HIST_AW    = (1 << K_W) - 1;
  localparam int HIST_DEPTH = 1 << HIST_AW;

  logic [BITS_ADC-1:0]      hist [HIST_DEPTH];
  logic [MA_ACUM_WIDTH-1:0] acc;
  logic [HIST_AW-1:0]       tap;

  // Oldest sample still inside the 2^k window.
  always_comb begin
    tap = '0;
    for (int i = 0; i < (1 << K_W); i++)
      if (k == K_W'(i)) tap = HIST_AW'((1 << i) - 1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst || restart) begin
      acc     <= '0;
      avg_vld <= 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else begin
      avg_vld <= sample_vld;
      if (sample_vld) begin
        acc     <= acc + MA_ACUM_WIDTH'(sample) - MA_ACUM_WIDTH'(hist[tap]);
        hist[0] <= sample;
        for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
      end
    end
  end

  assign avg = BITS_ADC'(acc >> k);
`else
  logic [BITS_ADC-1:0] stage;
  logic                k_unused;

  always_ff @(posedge clk_i) begin
    if (!rst || restart) begin
      stage   <= '0;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= sample_vld;
      if (sample_vld) stage <= sample;
    end
  end

  assign avg      = stage;
  assign k_unused = ^k;
`endif

  // si_data_o keeps its last value across a restart; only reset zeroes it.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      si_rdy_o  <= 1'b0;
      si_data_o <= '0;
    end else if (restart) begin
      si_rdy_o  <= 1'b0;
    end else begin
      si_rdy_o <= avg_vld;
      if (avg_vld) si_data_o <= avg;
    end
  end

endmodule

// File: tb/tb_adc_sampler_avg.sv
// tb_adc_sampler_avg: directed bench for adc_sampler_avg with a sample-stream reference model.
// Expectations follow ADC_SAMPLER_AVG_MA_EN the same way the design does.
module tb_adc_sampler_avg;

  logic        clk_i = 1'b0;
  logic        rst;
  logic [7:0]  adc_data_i;
  logic        adc_oe;
  logic        clk_o;
  logic [7:0]  si_data_o;
  logic        si_rdy_o;
  logic [15:0] reg_si_data;
  logic [7:0]  reg_si_addr;
  logic        reg_si_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] strobe_q[$];
  int         strobe_t[$];

  adc_sampler_avg dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .adc_data_i  (adc_data_i),
    .adc_oe      (adc_oe),
    .clk_o       (clk_o),
    .si_data_o   (si_data_o),
    .si_rdy_o    (si_rdy_o),
    .reg_si_data (reg_si_data),
    .reg_si_addr (reg_si_addr),
    .reg_si_rdy  (reg_si_rdy)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a list of decimated samples since the last clear, averaged over the
  // newest 2^k entries, with each result due two edges after its sample was captured.
  typedef struct { int at; logic [7:0] val; } pend_t;

  int          edge_no = 0;
  logic        restart_m = 1'b1;
  logic [31:0] df_m = 32'd0;
  logic [1:0]  k_m = 2'd3;
  longint      cap_idx = 0;
  logic [7:0]  win_q[$];
  pend_t       pend_q[$];
  logic        exp_rdy = 1'b0;
  logic [7:0]  exp_data = 8'h00;
  logic        exp_oe = 1'b0;

  always @(posedge clk_i) begin : model
    logic       is_clear;
    logic       wr;
    int         s;
    logic [7:0] v;
    edge_no++;
    is_clear = !rst || restart_m;
    wr = rst && reg_si_rdy && (reg_si_addr == 8'd0 || reg_si_addr == 8'd1 || reg_si_addr == 8'd2);
    if (is_clear)
      while (pend_q.size() > 0 && pend_q[pend_q.size()-1].at >= edge_no) void'(pend_q.pop_back());
    exp_rdy = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].at == edge_no) begin
      exp_rdy  = 1'b1;
      exp_data = pend_q[0].val;
      void'(pend_q.pop_front());
    end
    if (!rst) exp_data = 8'h00;
    if (is_clear) begin
      cap_idx = 0;
      win_q.delete();
    end else begin
      if ((cap_idx % (longint'(df_m) + 1)) == longint'(df_m)) begin
        win_q.push_back(adc_data_i);
        if (win_q.size() > 8) void'(win_q.pop_front());
`ifdef ADC_SAMPLER_AVG_MA_EN
        s = 0;
        for (int i = 0; i < (1 << k_m) && i < win_q.size(); i++) s += win_q[win_q.size()-1-i];
        v = 8'(s >> k_m);
`else
        v = adc_data_i;
`endif
        pend_q.push_back('{edge_no + 2, v});
      end
      cap_idx++;
    end
    if (!rst) begin
      df_m = 32'd0;
      k_m  = 2'd3;
    end else if (reg_si_rdy) begin
      if (reg_si_addr == 8'd0) df_m[15:0]  = reg_si_data;
      if (reg_si_addr == 8'd1) df_m[31:16] = reg_si_data;
      if (reg_si_addr == 8'd2) k_m = reg_si_data[1:0];
    end
    restart_m = !rst || wr;
    exp_oe    = !restart_m;
  end

  // Per-cycle compare against the model, plus a log of every strobe for the directed checks.
  always @(posedge clk_i) begin : compare
    #1;
    if (edge_no >= 1) begin
      check("si_rdy_o", si_rdy_o, exp_rdy);
      check("si_data_o", si_data_o, exp_data);
      check("adc_oe", adc_oe, exp_oe);
      check("clk_o", clk_o, 0);
      if (si_rdy_o === 1'b1) begin
        strobe_q.push_back(si_data_o);
        strobe_t.push_back(edge_no);
      end
    end
  end

  task automatic reg_write(input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk_i);
    reg_si_addr = addr;
    reg_si_data = data;
    reg_si_rdy  = 1'b1;
    @(negedge clk_i);
    reg_si_rdy  = 1'b0;
  endtask

  task automatic run_inc(input int n);
    repeat (n) begin
      @(negedge clk_i);
      adc_data_i = adc_data_i + 8'd1;
    end
  endtask

  task automatic clear_log();
    strobe_q.delete();
    strobe_t.delete();
  endtask

  task automatic compare_strobes(input string name);
    check({name, "_count"}, 32'(strobe_q.size() >= exp_q.size()), 1);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", name, i),
            (i < strobe_q.size()) ? {24'h0, strobe_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
  endtask

  initial begin
    int cnt;
    rst         = 1'b0;
    adc_data_i  = 8'h80;
    reg_si_data = '0;
    reg_si_addr = '0;
    reg_si_rdy  = 1'b0;

    // Reset defaults, then a constant 0x80 ramps up through the default k=3 window.
    repeat (2) @(negedge clk_i);
    check("reset_rdy", si_rdy_o, 0);
    check("reset_oe", adc_oe, 0);
    check("reset_data", si_data_o, 0);
    rst = 1'b1;
    clear_log();
    repeat (14) @(negedge clk_i);
`ifdef ADC_SAMPLER_AVG_MA_EN
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h80, 8'h80};
`else
    exp_q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
`endif
    compare_strobes("ramp");

    // Averaging math with k=2.
    reg_write(8'd2, 16'd2);
    clear_log();
    adc_data_i = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      adc_data_i = 8'(4 * i);
    end
    repeat (4) @(negedge clk_i);
`ifdef ADC_SAMPLER_AVG_MA_EN
    exp_q = '{8'd0, 8'd1, 8'd3, 8'd6, 8'd10};
`else
    exp_q = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd16};
`endif
    compare_strobes("avg_k2");

    // Decimation by 5 on an incrementing ramp.
    reg_write(8'd0, 16'd4);
    reg_write(8'd1, 16'd0);
    reg_write(8'd2, 16'd0);
    clear_log();
    adc_data_i = 8'd0;
    run_inc(24);
    exp_q = '{8'd5, 8'd10, 8'd15, 8'd20};
    compare_strobes("decim");
    for (int i = 1; i < 4; i++)
      check($sformatf("decim_gap[%0d]", i),
            (i < strobe_t.size()) ? strobe_t[i] - strobe_t[i-1] : -1, 5);

    // Restart on a k write mid-stream; an undecoded address changes nothing.
    adc_data_i = 8'h64;
    reg_write(8'd0, 16'd0);
    repeat (6) @(negedge clk_i);
    reg_write(8'd2, 16'd1);
    check("restart_oe_low", adc_oe, 0);
    clear_log();
    @(negedge clk_i);
    check("restart_oe_high", adc_oe, 1);
    repeat (5) @(negedge clk_i);
`ifdef ADC_SAMPLER_AVG_MA_EN
    exp_q = '{8'h32, 8'h64, 8'h64};
`else
    exp_q = '{8'h64, 8'h64, 8'h64};
`endif
    compare_strobes("restart_k1");
    clear_log();
    reg_write(8'd7, 16'h0003);
    check("addr7_oe", adc_oe, 1);
    repeat (4) @(negedge clk_i);
    exp_q = '{8'h64, 8'h64, 8'h64, 8'h64, 8'h64, 8'h64};
    compare_strobes("addr7");

    // Full-scale input with k=3 settles at exactly 0xFF.
    adc_data_i = 8'hFF;
    reg_write(8'd2, 16'd3);
    clear_log();
    repeat (14) @(negedge clk_i);
`ifdef ADC_SAMPLER_AVG_MA_EN
    exp_q = '{8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF, 8'hFF, 8'hFF, 8'hFF};
`else
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
    compare_strobes("full_scale");

    // df = 0x10000 uses the upper register half: first strobe 65540 falling edges after the write.
    reg_write(8'd1, 16'h0001);
    reg_write(8'd0, 16'h0000);
    clear_log();
    cnt = 0;
    while (si_rdy_o !== 1'b1 && cnt < 70000) begin
      @(negedge clk_i);
      cnt++;
    end
    check("df32_delay", cnt, 65540);
`ifdef ADC_SAMPLER_AVG_MA_EN
    check("df32_value", si_data_o, 8'h1F);
`else
    check("df32_value", si_data_o, 8'hFF);
`endif

    // Reset mid-stream with a coincident k write that must be ignored.
    @(negedge clk_i);
    adc_data_i  = 8'h80;
    rst         = 1'b0;
    reg_si_addr = 8'd2;
    reg_si_data = 16'd0;
    reg_si_rdy  = 1'b1;
    @(negedge clk_i);
    check("midrst_rdy", si_rdy_o, 0);
    check("midrst_data", si_data_o, 0);
    check("midrst_oe", adc_oe, 0);
    rst        = 1'b1;
    reg_si_rdy = 1'b0;
    clear_log();
    repeat (8) @(negedge clk_i);
`ifdef ADC_SAMPLER_AVG_MA_EN
    exp_q = '{8'h10, 8'h20, 8'h30};
`else
    exp_q = '{8'h80, 8'h80, 8'h80};
`endif
    compare_strobes("midrst_ramp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
